pwm_deadtime_gate: RTL and testbench

//  Downstream of the FOC core: turns the three single-ended PWM phases (pwmA/B/C) into complementary

---
 rtl/pwm_deadtime_gate.sv | 214 +++++++++++++++++++++
 tb/tb_pwm_deadtime_gate.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_deadtime_gate.sv
// pwm_deadtime_gate
// Turns three single-ended PWM phase commands into complementary high/low
// gate drives with programmable dead time, a low-side bootstrap pre-charge
// phase on arm, and a latched fault shutdown. Everything runs on clk_sys.
//
// Optional build macro: GATE_FAULT_FILTER_EN
//   defined   -> fault_in must be high for FAULT_FILT consecutive cycles to trip
//   undefined -> fault_in trips on the first clock edge that samples it high
module pwm_deadtime_gate #(
  parameter int DT_WIDTH   = 8,
  parameter int ARM_CYCLES = 256,
  parameter int FAULT_FILT = 4
) (
  input  logic                clk_sys,
  input  logic                rst,
  input  logic                enable,
  input  logic                pwmA_in,
  input  logic                pwmB_in,
  input  logic                pwmC_in,
  input  logic [DT_WIDTH-1:0] dead_time,
  input  logic                fault_in,
  input  logic                fault_clr,
  output logic                gateA_hi,
  output logic                gateA_lo,
  output logic                gateB_hi,
  output logic                gateB_lo,
  output logic                gateC_hi,
  output logic                gateC_lo,
  output logic                running,
  output logic                fault_latched
);

  localparam int ARM_W = $clog2(ARM_CYCLES + 1);

  typedef enum logic [1:0] {
    G_DISABLED,
    G_ARMING,
    G_RUN,
    G_FAULT
  } global_state_t;

  typedef enum logic [1:0] {
    P_LO_ON,
    P_DEAD_R,
    P_HI_ON,
    P_DEAD_F
  } phase_state_t;

  global_state_t       g_state;
  logic [ARM_W-1:0]    arm_cnt;
  phase_state_t        ph_state [3];
  logic [DT_WIDTH-1:0] ph_cnt   [3];
  logic [2:0]          gate_hi;
  logic [2:0]          gate_lo;
  logic [2:0]          pwm_vec;
  logic [DT_WIDTH-1:0] dt_load;
  logic                trip;

  assign pwm_vec = {pwmC_in, pwmB_in, pwmA_in};

  // A dead time of zero is clamped to one cycle, so the count loaded is max(dt,1)-1.
  assign dt_load = (dead_time == '0) ? '0 : dead_time - DT_WIDTH'(1);

`ifdef GATE_FAULT_FILTER_EN
  localparam int FILT_W = $clog2(FAULT_FILT + 1);

  logic [FILT_W-1:0] filt_cnt;

  // Saturating run-length counter of consecutive fault_in-high cycles.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      filt_cnt <= '0;
    end else if (!fault_in) begin
      filt_cnt <= '0;
    end else if (filt_cnt != FILT_W'(FAULT_FILT)) begin
      filt_cnt <= filt_cnt + FILT_W'(1);
    end
  end

  assign trip = fault_in && (filt_cnt >= FILT_W'(FAULT_FILT - 1));
`else
  // Without the filter the filter length has no role; tie it off to a named sink.
  logic unused_filt_cfg;
  assign unused_filt_cfg = (FAULT_FILT > 0);

  assign trip = fault_in;
`endif

  // Global arm/run/fault sequencer plus the three phase dead-time FSMs; every
  // output is a register so the gates never glitch.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      g_state       <= G_DISABLED;
      arm_cnt       <= '0;
      gate_hi       <= '0;
      gate_lo       <= '0;
      running       <= 1'b0;
      fault_latched <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        ph_state[i] <= P_LO_ON;
        ph_cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        ph_state[i] <= P_LO_ON;
        ph_cnt[i]   <= '0;
      end
      gate_hi <= '0;
      gate_lo <= '0;
      running <= 1'b0;

      if (trip) begin
        g_state       <= G_FAULT;
        fault_latched <= 1'b1;
      end else begin
        case (g_state)
          G_DISABLED: begin
            if (enable) begin
              g_state <= G_ARMING;
              arm_cnt <= ARM_W'(ARM_CYCLES - 1);
              gate_lo <= '1;
            end
          end

          G_ARMING: begin
            if (!enable) begin
              g_state <= G_DISABLED;
            end else if (arm_cnt == '0) begin
              g_state <= G_RUN;
              running <= 1'b1;
              gate_lo <= '1;
            end else begin
              arm_cnt <= arm_cnt - ARM_W'(1);
              gate_lo <= '1;
            end
          end

          G_RUN: begin
            if (!enable) begin
              g_state <= G_DISABLED;
            end else begin
              running <= 1'b1;
              for (int i = 0; i < 3; i++) begin
                case (ph_state[i])
                  P_LO_ON: begin
                    if (pwm_vec[i]) begin
                      ph_state[i] <= P_DEAD_R;
                      ph_cnt[i]   <= dt_load;
                    end else begin
                      gate_lo[i]  <= 1'b1;
                    end
                  end
                  P_DEAD_R: begin
                    if (!pwm_vec[i]) begin
                      gate_lo[i]  <= 1'b1;
                    end else if (ph_cnt[i] == '0) begin
                      ph_state[i] <= P_HI_ON;
                      gate_hi[i]  <= 1'b1;
                    end else begin
                      ph_state[i] <= P_DEAD_R;
                      ph_cnt[i]   <= ph_cnt[i] - DT_WIDTH'(1);
                    end
                  end
                  P_HI_ON: begin
                    if (!pwm_vec[i]) begin
                      ph_state[i] <= P_DEAD_F;
                      ph_cnt[i]   <= dt_load;
                    end else begin
                      ph_state[i] <= P_HI_ON;
                      gate_hi[i]  <= 1'b1;
                    end
                  end
                  P_DEAD_F: begin
                    if (pwm_vec[i]) begin
                      ph_state[i] <= P_HI_ON;
                      gate_hi[i]  <= 1'b1;
                    end else if (ph_cnt[i] == '0) begin
                      gate_lo[i]  <= 1'b1;
                    end else begin
                      ph_state[i] <= P_DEAD_F;
                      ph_cnt[i]   <= ph_cnt[i] - DT_WIDTH'(1);
                    end
                  end
                  default: begin
                    gate_lo[i] <= 1'b1;
                  end
                endcase
              end
            end
          end

          G_FAULT: begin
            if (fault_clr && !fault_in && !enable) begin
              g_state       <= G_DISABLED;
              fault_latched <= 1'b0;
            end
          end

          default: begin
            g_state <= G_DISABLED;
          end
        endcase
      end
    end
  end

  assign gateA_hi = gate_hi[0];
  assign gateA_lo = gate_lo[0];
  assign gateB_hi = gate_hi[1];
  assign gateB_lo = gate_lo[1];
  assign gateC_hi = gate_hi[2];
  assign gateC_lo = gate_lo[2];

endmodule

// File: tb/tb_pwm_deadtime_gate.sv
// tb_pwm_deadtime_gate
// Directed self-checking bench for pwm_deadtime_gate: arming, dead time,
// glitch swallowing, dead-time clamp, fault latch/clear and re-arm.
// Honours GATE_FAULT_FILTER_EN when the design is built with it.
module tb_pwm_deadtime_gate;

  localparam int ARM = 256;
`ifdef GATE_FAULT_FILTER_EN
  localparam int TRIP_LEN = 4;
`else
  localparam int TRIP_LEN = 1;
`endif

  // Gate bus order {A_hi, A_lo, B_hi, B_lo, C_hi, C_lo}
  localparam logic [7:0] ALL_OFF = 8'b00_000000;
  localparam logic [7:0] ALL_LO  = 8'b00_010101;

  logic       clk_sys   = 1'b0;
  logic       rst       = 1'b1;
  logic       enable    = 1'b0;
  logic       pwmA_in   = 1'b0;
  logic       pwmB_in   = 1'b0;
  logic       pwmC_in   = 1'b0;
  logic [7:0] dead_time = 8'd0;
  logic       fault_in  = 1'b0;
  logic       fault_clr = 1'b0;
  logic       gateA_hi, gateA_lo, gateB_hi, gateB_lo, gateC_hi, gateC_lo;
  logic       running, fault_latched;

  int testsRun    = 0;
  int testsFailed = 0;

  pwm_deadtime_gate #(
    .DT_WIDTH  (8),
    .ARM_CYCLES(ARM),
    .FAULT_FILT(4)
  ) dut (
    .clk_sys      (clk_sys),
    .rst          (rst),
    .enable       (enable),
    .pwmA_in      (pwmA_in),
    .pwmB_in      (pwmB_in),
    .pwmC_in      (pwmC_in),
    .dead_time    (dead_time),
    .fault_in     (fault_in),
    .fault_clr    (fault_clr),
    .gateA_hi     (gateA_hi),
    .gateA_lo     (gateA_lo),
    .gateB_hi     (gateB_hi),
    .gateB_lo     (gateB_lo),
    .gateC_hi     (gateC_hi),
    .gateC_lo     (gateC_lo),
    .running      (running),
    .fault_latched(fault_latched)
  );

  // 100 MHz system clock
  always #5 clk_sys = ~clk_sys;

  function automatic logic [7:0] gates();
    return {2'b00, gateA_hi, gateA_lo, gateB_hi, gateB_lo, gateC_hi, gateC_lo};
  endfunction

  // Count one comparison and report it if the observed value is wrong
  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", tag, actual, expected, $time);
    end
  endtask

  // Drive the PWM commands and dead time, then advance the given number of cycles
  task automatic applyStimulus(input logic [2:0] pwm, input logic [7:0] dt, input int cycles);
    pwmA_in   = pwm[0];
    pwmB_in   = pwm[1];
    pwmC_in   = pwm[2];
    dead_time = dt;
    repeat (cycles) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  // Shoot-through must never happen on any phase, in any state
  always @(negedge clk_sys) begin
    checkOutput("no_shoot_through",
                {5'b0, gateA_hi & gateA_lo, gateB_hi & gateB_lo, gateC_hi & gateC_lo}, 8'd0);
  end

  // Directed test sequence
  initial begin
    applyStimulus(3'b000, 8'd0, 2);
    checkOutput("reset_gates", gates(), ALL_OFF);
    checkOutput("reset_running", {7'b0, running}, 8'd0);
    checkOutput("reset_fault", {7'b0, fault_latched}, 8'd0);

    rst = 1'b0;
    applyStimulus(3'b000, 8'd0, 2);
    checkOutput("disabled_gates", gates(), ALL_OFF);

    enable = 1'b1;
    for (int i = 1; i <= ARM; i++) begin
      applyStimulus(3'b000, 8'd0, 1);
      checkOutput("arm_lo", gates(), ALL_LO);
      checkOutput("arm_not_running", {7'b0, running}, 8'd0);
    end
    applyStimulus(3'b000, 8'd0, 1);
    checkOutput("run_entry_running", {7'b0, running}, 8'd1);
    checkOutput("run_entry_gates", gates(), ALL_LO);

    for (int k = 1; k <= 11; k++) begin
      applyStimulus(3'b001, 8'd10, 1);
      checkOutput("dt_rise_A", gates(), (k <= 10) ? 8'b00_000101 : 8'b00_100101);
    end
    for (int k = 1; k <= 11; k++) begin
      applyStimulus(3'b000, (k == 1) ? 8'd10 : 8'd3, 1);
      checkOutput("dt_fall_A", gates(), (k <= 10) ? 8'b00_000101 : ALL_LO);
    end

    for (int k = 1; k <= 3; k++) begin
      applyStimulus(3'b010, 8'd8, 1);
      checkOutput("glitch_B_off", gates(), 8'b00_010001);
    end
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(3'b000, 8'd8, 1);
      checkOutput("glitch_B_lo", gates(), ALL_LO);
    end

    for (int rep = 0; rep < 2; rep++) begin
      applyStimulus(3'b100, 8'd0, 1);
      checkOutput("clamp_rise_off", gates(), 8'b00_010100);
      applyStimulus(3'b100, 8'd0, 1);
      checkOutput("clamp_hi", gates(), 8'b00_010110);
      applyStimulus(3'b000, 8'd0, 1);
      checkOutput("clamp_fall_off", gates(), 8'b00_010100);
      applyStimulus(3'b000, 8'd0, 1);
      checkOutput("clamp_lo", gates(), ALL_LO);
    end

    applyStimulus(3'b001, 8'd1, 1);
    checkOutput("pre_fault_A_off", gates(), 8'b00_000101);
    applyStimulus(3'b001, 8'd1, 1);
    checkOutput("pre_fault_A_hi", gates(), 8'b00_100101);
    fault_in = 1'b1;
    applyStimulus(3'b001, 8'd1, TRIP_LEN);
    fault_in = 1'b0;
    checkOutput("fault_gates", gates(), ALL_OFF);
    checkOutput("fault_latched", {7'b0, fault_latched}, 8'd1);
    checkOutput("fault_not_running", {7'b0, running}, 8'd0);

    fault_clr = 1'b1;
    applyStimulus(3'b001, 8'd1, 1);
    fault_clr = 1'b0;
    checkOutput("clr_while_enabled", {7'b0, fault_latched}, 8'd1);
    checkOutput("clr_while_enabled_gates", gates(), ALL_OFF);

    enable    = 1'b0;
    fault_clr = 1'b1;
    applyStimulus(3'b000, 8'd1, 1);
    fault_clr = 1'b0;
    checkOutput("clr_disabled_fault", {7'b0, fault_latched}, 8'd0);
    checkOutput("clr_disabled_gates", gates(), ALL_OFF);

    fault_in = 1'b1;
    applyStimulus(3'b000, 8'd1, TRIP_LEN);
    checkOutput("trip_from_disabled", {7'b0, fault_latched}, 8'd1);
    fault_clr = 1'b1;
    applyStimulus(3'b000, 8'd1, 1);
    checkOutput("trip_beats_clr", {7'b0, fault_latched}, 8'd1);
    fault_in = 1'b0;
    applyStimulus(3'b000, 8'd1, 1);
    fault_clr = 1'b0;
    checkOutput("clr_after_trip", {7'b0, fault_latched}, 8'd0);

    enable = 1'b1;
    for (int i = 1; i <= ARM; i++) begin
      applyStimulus(3'b100, 8'd2, 1);
      checkOutput("rearm_lo", gates(), ALL_LO);
    end
    applyStimulus(3'b100, 8'd2, 1);
    checkOutput("rearm_running", {7'b0, running}, 8'd1);
    checkOutput("rearm_entry_lo", gates(), ALL_LO);
    applyStimulus(3'b100, 8'd2, 1);
    checkOutput("rearm_C_dead1", gates(), 8'b00_010100);
    applyStimulus(3'b100, 8'd2, 1);
    checkOutput("rearm_C_dead2", gates(), 8'b00_010100);
    applyStimulus(3'b100, 8'd2, 1);
    checkOutput("rearm_C_hi", gates(), 8'b00_010110);

    enable = 1'b0;
    applyStimulus(3'b100, 8'd2, 1);
    checkOutput("disable_gates", gates(), ALL_OFF);
    checkOutput("disable_running", {7'b0, running}, 8'd0);

    enable = 1'b1;
    applyStimulus(3'b000, 8'd2, 1);
    checkOutput("abort_arm_lo", gates(), ALL_LO);
    enable = 1'b0;
    applyStimulus(3'b000, 8'd2, 1);
    checkOutput("abort_arm_off", gates(), ALL_OFF);

`ifdef GATE_FAULT_FILTER_EN
    fault_in = 1'b1;
    applyStimulus(3'b000, 8'd2, 3);
    fault_in = 1'b0;
    applyStimulus(3'b000, 8'd2, 1);
    checkOutput("filter_short_pulse", {7'b0, fault_latched}, 8'd0);
    fault_in = 1'b1;
    applyStimulus(3'b000, 8'd2, 4);
    fault_in = 1'b0;
    checkOutput("filter_long_pulse", {7'b0, fault_latched}, 8'd1);
    fault_clr = 1'b1;
    applyStimulus(3'b000, 8'd2, 1);
    fault_clr = 1'b0;
    checkOutput("filter_clear", {7'b0, fault_latched}, 8'd0);
`endif

    applyStimulus(3'b000, 8'd0, 2);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
